// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared definitions for the UART receiver frame sequencer:
//               FSM state encoding, the legal oversampling ratios expressed
//               as Prescale values, and the default frame data width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Default number of data bits per frame
    localparam int c_DEFAULT_DATA_W = 8;

    // Legal Prescale settings (bit period minus 1) for 8x, 16x, 32x sampling
    localparam int c_PRESCALE_X8  = 7;
    localparam int c_PRESCALE_X16 = 15;
    localparam int c_PRESCALE_X32 = 31;

    // Frame sequencer states, 3-bit binary
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_e;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fsm_if
// Description : Signal bundle between the UART RX frame sequencer and its
//               neighbours (edge/bit counter, sampler, deserializer,
//               start/parity/stop checkers).
//   slave  modport : the sequencer itself
//   master modport : the surrounding RX top level
//   Inputs to sequencer : RX_IN, PAR_EN, Prescale, bit_cnt, edge_cnt,
//                         strt_glitch, par_err, stp_err
//   Outputs of sequencer: enable, dat_samp_en, deser_en, strt_chk_en,
//                         par_chk_en, stp_chk_en, data_valid
//                         (+ parity_error, framing_error when
//                          UART_RX_FSM_ERR_FLAGS_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fsm_if #(
    parameter int PRESCALE_W = 5,
    parameter int BIT_CNT_W  = 4
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic [PRESCALE_W-1:0] Prescale;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;

    logic                  enable;
    logic                  dat_samp_en;
    logic                  deser_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  data_valid;

`ifdef UART_RX_FSM_ERR_FLAGS_EN
    logic                  parity_error;
    logic                  framing_error;

    modport slave (
        input  RX_IN, PAR_EN, Prescale, bit_cnt, edge_cnt,
               strt_glitch, par_err, stp_err,
        output enable, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid,
               parity_error, framing_error
    );

    modport master (
        output RX_IN, PAR_EN, Prescale, bit_cnt, edge_cnt,
               strt_glitch, par_err, stp_err,
        input  enable, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid,
               parity_error, framing_error
    );
`else
    modport slave (
        input  RX_IN, PAR_EN, Prescale, bit_cnt, edge_cnt,
               strt_glitch, par_err, stp_err,
        output enable, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid
    );

    modport master (
        output RX_IN, PAR_EN, Prescale, bit_cnt, edge_cnt,
               strt_glitch, par_err, stp_err,
        input  enable, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid
    );
`endif

endinterface : uart_rx_fsm_if
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fsm
// Description : UART receiver frame sequencer. Detects the start condition,
//               gates the external edge/bit counter, schedules the sampler,
//               deserializer and start/parity/stop checkers at fixed edge
//               positions and pulses data_valid for every error-free frame.
// Ports       :
//   uart_rx_fsm_clk  in  clock
//   uart_rx_fsm_rst  in  asynchronous reset, active-low
//   rx_if            uart_rx_fsm_if.slave bundle (see interface header)
// Optional    : UART_RX_FSM_ERR_FLAGS_EN adds parity_error / framing_error
//               one-cycle pulses on the interface.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = c_DEFAULT_DATA_W,
    parameter int PRESCALE_W = 5,
    parameter int BIT_CNT_W  = 4
) (
    input  wire          uart_rx_fsm_clk,
    input  wire          uart_rx_fsm_rst,
    uart_rx_fsm_if.slave rx_if
);

    localparam logic [BIT_CNT_W-1:0]  c_LAST_DATA_BIT = BIT_CNT_W'(DATA_W);
    localparam logic [PRESCALE_W-1:0] c_ONE           = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] c_TWO           = PRESCALE_W'(2);

    uart_rx_state_e state_q, state_d;
    logic par_en_q,      par_en_d;
    logic enable_q,      enable_d;
    logic dat_samp_en_q, dat_samp_en_d;
    logic deser_en_q,    deser_en_d;
    logic strt_chk_en_q, strt_chk_en_d;
    logic par_chk_en_q,  par_chk_en_d;
    logic stp_chk_en_q,  stp_chk_en_d;
    logic data_valid_q,  data_valid_d;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
    logic parity_error_q,  parity_error_d;
    logic framing_error_q, framing_error_d;
`endif

    logic [PRESCALE_W-1:0] w_mid;
    logic [PRESCALE_W-1:0] w_edge_nxt;
    logic                  w_bit_end;
    logic                  w_active_nxt;
    logic                  w_samp_win;
    logic                  w_strobe_pos;

    assign w_mid     = rx_if.Prescale >> 1;
    assign w_bit_end = enable_q && (rx_if.edge_cnt == rx_if.Prescale);

    // All outputs are registered, yet must be visible while the counter
    // shows the target edge. Decode against the counter value for the next
    // cycle instead: the counter clears while enable is low and wraps at
    // bit_end, otherwise it advances by one.
    assign w_edge_nxt = !enable_q  ? '0 :
                        w_bit_end  ? '0 :
                        rx_if.edge_cnt + c_ONE;

    assign w_samp_win   = (w_edge_nxt >= (w_mid - c_ONE)) &&
                          (w_edge_nxt <= (w_mid + c_ONE));
    assign w_strobe_pos = (w_edge_nxt == (w_mid + c_TWO));

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        par_en_d        = par_en_q;
        data_valid_d    = 1'b0;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
        parity_error_d  = 1'b0;
        framing_error_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (!rx_if.RX_IN) begin
                    state_d  = START;
                    par_en_d = rx_if.PAR_EN;
                end
            end
            START: begin
                if (w_bit_end) begin
                    state_d = rx_if.strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_end && (rx_if.bit_cnt == c_LAST_DATA_BIT)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    if (rx_if.par_err) begin
                        state_d = IDLE;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
                        parity_error_d = 1'b1;
`endif
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    state_d      = IDLE;
                    data_valid_d = !rx_if.stp_err;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
                    framing_error_d = rx_if.stp_err;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter enable follows the state it will be in next cycle, so
        // it rises together with START and falls together with IDLE.
        w_active_nxt  = (state_d != IDLE);
        enable_d      = w_active_nxt;
        dat_samp_en_d = w_active_nxt && w_samp_win;

        // The states are mutually exclusive, so at most one strobe fires.
        strt_chk_en_d = w_strobe_pos && (state_d == START);
        deser_en_d    = w_strobe_pos && (state_d == DATA);
        par_chk_en_d  = w_strobe_pos && (state_d == PARITY);
        stp_chk_en_d  = w_strobe_pos && (state_d == STOP);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge uart_rx_fsm_clk or negedge uart_rx_fsm_rst) begin
        if (!uart_rx_fsm_rst) begin
            state_q         <= IDLE;
            par_en_q        <= 1'b0;
            enable_q        <= 1'b0;
            dat_samp_en_q   <= 1'b0;
            deser_en_q      <= 1'b0;
            strt_chk_en_q   <= 1'b0;
            par_chk_en_q    <= 1'b0;
            stp_chk_en_q    <= 1'b0;
            data_valid_q    <= 1'b0;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            par_en_q        <= par_en_d;
            enable_q        <= enable_d;
            dat_samp_en_q   <= dat_samp_en_d;
            deser_en_q      <= deser_en_d;
            strt_chk_en_q   <= strt_chk_en_d;
            par_chk_en_q    <= par_chk_en_d;
            stp_chk_en_q    <= stp_chk_en_d;
            data_valid_q    <= data_valid_d;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
`endif
        end
    end

    assign rx_if.enable      = enable_q;
    assign rx_if.dat_samp_en = dat_samp_en_q;
    assign rx_if.deser_en    = deser_en_q;
    assign rx_if.strt_chk_en = strt_chk_en_q;
    assign rx_if.par_chk_en  = par_chk_en_q;
    assign rx_if.stp_chk_en  = stp_chk_en_q;
    assign rx_if.data_valid  = data_valid_q;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
    assign rx_if.parity_error  = parity_error_q;
    assign rx_if.framing_error = framing_error_q;
`endif

endmodule : uart_rx_fsm
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fsm
// Description : Self-checking bench for uart_rx_fsm. Models the edge/bit
//               counter, the deserializer and the start/parity/stop
//               checkers around the sequencer; a scoreboard queue holds the
//               bytes expected on data_valid, and a monitor checks strobe
//               placement and per-frame pulse counts.
// Optional    : UART_RX_FSM_ERR_FLAGS_EN enables error-flag checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    localparam int DATA_W     = 8;
    localparam int PRESCALE_W = 5;
    localparam int BIT_CNT_W  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fsm_if #(.PRESCALE_W(PRESCALE_W), .BIT_CNT_W(BIT_CNT_W)) bus ();

    uart_rx_fsm #(
        .DATA_W     (DATA_W),
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) dut (
        .uart_rx_fsm_clk (clk),
        .uart_rx_fsm_rst (rst_n),
        .rx_if           (bus)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] nb;   // bit_cnt shown by the counter on the data_valid cycle
    } exp_t;
    exp_t exp_q[$];

    // ---------------- edge/bit counter model ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= '0;
        end else if (!bus.enable) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= '0;
        end else if (bus.edge_cnt == bus.Prescale) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= bus.bit_cnt + 1'b1;
        end else begin
            bus.edge_cnt <= bus.edge_cnt + 1'b1;
        end
    end

    // ---------------- deserializer and checker models (even parity) ----------------
    logic [7:0] shreg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg           <= '0;
            bus.strt_glitch <= 1'b0;
            bus.par_err     <= 1'b0;
            bus.stp_err     <= 1'b0;
        end else begin
            if (bus.deser_en)    shreg           <= {bus.RX_IN, shreg[7:1]};
            if (bus.strt_chk_en) bus.strt_glitch <= bus.RX_IN;
            if (bus.par_chk_en)  bus.par_err     <= bus.RX_IN ^ (^shreg);
            if (bus.stp_chk_en)  bus.stp_err     <= ~bus.RX_IN;
        end
    end

    // ---------------- monitor ----------------
    int cnt_en = 0, cnt_deser = 0, cnt_strt = 0, cnt_par = 0, cnt_stp = 0, cnt_dv = 0;
    int cnt_perr = 0, cnt_ferr = 0;
    int mid_m;
    int edge_m;
    logic [3:0] strb;
    logic samp_exp;
    exp_t popped;

    always @(negedge clk) begin
        mid_m  = int'(bus.Prescale) >> 1;
        edge_m = int'(bus.edge_cnt);
        strb   = {bus.strt_chk_en, bus.deser_en, bus.par_chk_en, bus.stp_chk_en};

        if (bus.enable)      cnt_en++;
        if (bus.strt_chk_en) cnt_strt++;
        if (bus.deser_en)    cnt_deser++;
        if (bus.par_chk_en)  cnt_par++;
        if (bus.stp_chk_en)  cnt_stp++;
        if (bus.data_valid)  cnt_dv++;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
        if (bus.parity_error)  cnt_perr++;
        if (bus.framing_error) cnt_ferr++;
`endif

        if (strb != 4'b0000) begin
            chk("strobe_onehot", int'($onehot(strb)), 1);
            chk("strobe_edge", edge_m, mid_m + 2);
            chk("strobe_enabled", int'(bus.enable), 1);
        end

        if (bus.enable || bus.dat_samp_en) begin
            samp_exp = bus.enable && (edge_m >= mid_m - 1) && (edge_m <= mid_m + 1);
            chk("samp_window", int'(bus.dat_samp_en), int'(samp_exp));
        end

        if (bus.data_valid) begin
            if (exp_q.size() == 0) begin
                chk("dv_unexpected", 1, 0);
            end else begin
                popped = exp_q.pop_front();
                chk("dv_byte", int'(shreg), int'(popped.d));
                chk("dv_bitcnt", int'(bus.bit_cnt), int'(popped.nb));
                chk("dv_edge0", edge_m, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    int s_en, s_deser, s_strt, s_par, s_stp, s_dv, s_perr, s_ferr;

    task automatic snap();
        s_en = cnt_en; s_deser = cnt_deser; s_strt = cnt_strt; s_par = cnt_par;
        s_stp = cnt_stp; s_dv = cnt_dv; s_perr = cnt_perr; s_ferr = cnt_ferr;
    endtask

    task automatic send_bit(input logic b);
        bus.RX_IN = b;
        repeat (int'(bus.Prescale) + 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        bus.RX_IN = 1'b1;
        repeat (n * (int'(bus.Prescale) + 1)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe,
                              input logic par_flip, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pe) send_bit((^d) ^ par_flip);
        send_bit(stp);
    endtask

    function automatic int outs_vec();
        return int'({bus.enable, bus.dat_samp_en, bus.deser_en, bus.strt_chk_en,
                     bus.par_chk_en, bus.stp_chk_en, bus.data_valid});
    endfunction

    initial begin
        bus.RX_IN    = 1'b1;
        bus.PAR_EN   = 1'b0;
        bus.Prescale = PRESCALE_W'(c_PRESCALE_X8);
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_vec(), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_enable", int'(bus.enable), 0);

        // T1: Prescale=7, no parity, 0xA5
        snap();
        exp_q.push_back('{d: 8'hA5, nb: 4'd10});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle_bits(3);
        chk("t1_deser", cnt_deser - s_deser, 8);
        chk("t1_dv", cnt_dv - s_dv, 1);
        chk("t1_par", cnt_par - s_par, 0);
        chk("t1_enable_cycles", cnt_en - s_en, 80);
        chk("t1_idle", int'(bus.enable), 0);
`ifdef UART_RX_FSM_ERR_FLAGS_EN
        chk("t1_flags", (cnt_perr - s_perr) + (cnt_ferr - s_ferr), 0);
`endif

        // T2: Prescale=15, parity, good parity
        bus.Prescale = PRESCALE_W'(c_PRESCALE_X16);
        bus.PAR_EN   = 1'b1;
        snap();
        exp_q.push_back('{d: 8'h3C, nb: 4'd11});
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle_bits(3);
        chk("t2_strt", cnt_strt - s_strt, 1);
        chk("t2_deser", cnt_deser - s_deser, 8);
        chk("t2_par", cnt_par - s_par, 1);
        chk("t2_stp", cnt_stp - s_stp, 1);
        chk("t2_dv", cnt_dv - s_dv, 1);
        chk("t2_enable_cycles", cnt_en - s_en, 176);

        // T3: Prescale=7, parity error -> frame dropped
        bus.Prescale = PRESCALE_W'(c_PRESCALE_X8);
        snap();
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
        bus.PAR_EN = 1'b0;
        idle_bits(3);
        chk("t3_par", cnt_par - s_par, 1);
        chk("t3_stp", cnt_stp - s_stp, 0);
        chk("t3_dv", cnt_dv - s_dv, 0);
        chk("t3_enable_cycles", cnt_en - s_en, 80);
`ifdef UART_RX_FSM_ERR_FLAGS_EN
        chk("t3_parity_error", cnt_perr - s_perr, 1);
`endif

        // T4: start glitch, RX_IN low for 2 clocks
        snap();
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        idle_bits(4);
        chk("t4_enable_cycles", cnt_en - s_en, 8);
        chk("t4_strt", cnt_strt - s_strt, 1);
        chk("t4_deser", cnt_deser - s_deser, 0);
        chk("t4_dv", cnt_dv - s_dv, 0);

        // T5: reset during data bit 4, then a clean frame
        snap();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.RX_IN = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_pre_enable", int'(bus.enable), 1);
        chk("t5_pre_bitcnt", int'(bus.bit_cnt), 4);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outputs", outs_vec(), 0);
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        chk("t5_no_dv", cnt_dv - s_dv, 0);
        snap();
        exp_q.push_back('{d: 8'h5A, nb: 4'd10});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        idle_bits(3);
        chk("t5_dv", cnt_dv - s_dv, 1);

        // T7: stop-bit error -> no data_valid
        snap();
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        idle_bits(3);
        chk("t7_stp", cnt_stp - s_stp, 1);
        chk("t7_dv", cnt_dv - s_dv, 0);
        chk("t7_enable_cycles", cnt_en - s_en, 80);
`ifdef UART_RX_FSM_ERR_FLAGS_EN
        chk("t7_framing_error", cnt_ferr - s_ferr, 1);
`endif

        // T6: back-to-back frames at Prescale=31
        bus.Prescale = PRESCALE_W'(c_PRESCALE_X32);
        snap();
        exp_q.push_back('{d: 8'hC3, nb: 4'd10});
        exp_q.push_back('{d: 8'h81, nb: 4'd10});
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle_bits(3);
        chk("t6_dv", cnt_dv - s_dv, 2);
        chk("t6_deser", cnt_deser - s_deser, 16);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d",
                 n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_rx_fsm
`default_nettype wire

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Frame-sequencing controller for the UART receiver. It detects the start condition on RX_IN and gates the edge/bit counter through its enable. It schedules the data sampler, deserializer and start/parity/stop checkers at fixed edge positions, and issues a one-cycle data_valid for every error-free frame. It sits at the RX top level beside the counter, sampler, deserializer and checkers.

Parameters:
DATA_W, 8, data bits per frame
PRESCALE_W, 5, width of Prescale and edge_cnt
BIT_CNT_W, 4, width of bit_cnt; must hold DATA_W+2

Ports:
uart_rx_fsm_clk  in  1  clock
uart_rx_fsm_rst  in  1  asynchronous reset, active-low
RX_IN  in  1  serial line, already synchronised
PAR_EN  in  1  parity bit present in frame
Prescale  in  PRESCALE_W  bit period minus 1; legal values 7, 15, 31
bit_cnt  in  BIT_CNT_W  from edge/bit counter
edge_cnt  in  PRESCALE_W  from edge/bit counter
strt_glitch  in  1  start checker result, registered, valid from the cycle after strt_chk_en
par_err  in  1  parity checker result, same timing as strt_glitch
stp_err  in  1  stop checker result, same timing as strt_glitch
enable  out  1  counter enable
dat_samp_en  out  1  sampler enable
deser_en  out  1  deserializer shift strobe
strt_chk_en  out  1  start check strobe
par_chk_en  out  1  parity check strobe
stp_chk_en  out  1  stop check strobe
data_valid  out  1  frame-good pulse

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; latched parity-enable cleared.
- Bit period = Prescale+1 clocks. Counter holds 0/0 while enable=0. A bit ends on the cycle where edge_cnt==Prescale ("bit_end").
- mid = Prescale>>1.
- dat_samp_en = 1 in any non-IDLE state while edge_cnt is in mid-1..mid+1.
- The check/shift strobe is a 1-cycle pulse at edge_cnt==mid+2, chosen by state: START gives strt_chk_en, DATA gives deser_en, PARITY gives par_chk_en, STOP gives stp_chk_en.
- Checker results are evaluated at bit_end.
- States and transitions (all outputs registered):
  - IDLE: enable=0. When RX_IN==0, go to START, set enable=1, and latch PAR_EN into par_en_q.
  - START: at bit_end, go to IDLE if strt_glitch, otherwise go to DATA.
  - DATA: at bit_end with bit_cnt==DATA_W, go to PARITY if par_en_q, otherwise go to STOP.
  - PARITY: at bit_end, go to IDLE if par_err (frame dropped, no data_valid), otherwise go to STOP.
  - STOP: at bit_end, go to IDLE. Set data_valid=1 for exactly one cycle iff stp_err==0.
- enable drops in the cycle after any return to IDLE, which clears the counter. A following start bit is detected from IDLE with up to 2 cycles of latency. The sampling offset this introduces is tolerated.
- PAR_EN and Prescale changes mid-frame: PAR_EN is ignored until the next IDLE→START. Prescale must be static while enable=1; behaviour otherwise is undefined.
- Glitch case: RX_IN returning high before mid is caught by the start checker and the FSM returns to IDLE at the end of the start bit.
- Reset mid-frame: immediate IDLE, no data_valid, all strobes 0.
- No strobe is asserted in IDLE. At most one of the check/shift strobes is high in any cycle.

Optional Feature:
UART_RX_FSM_ERR_FLAGS_EN
- When defined, two extra outputs exist: parity_error and framing_error, both 1 bit.
  - parity_error pulses 1 cycle at the PARITY→IDLE transition on par_err.
  - framing_error pulses 1 cycle at the STOP bit_end when stp_err==1.
  - Both reset to 0.
- When undefined, these ports and their logic are absent and all other behaviour is identical.

Decomposition:
- Shared package uart_rx_pkg holds:
  - State encodings IDLE, START, DATA, PARITY, STOP (3-bit binary).
  - Legal Prescale constants 7, 15, 31.
  - Default DATA_W.
- No sub-module: the next-state and output decode live in one module. The edge/bit counter is instantiated beside it at the RX top level, not inside it.

Test Plan:
- Prescale=7, PAR_EN=0, frame 0xA5 with good start/stop bits → deser_en pulses 8 times at edge_cnt==5; data_valid=1 for one cycle 1 clock after the stop-bit end; state returns to IDLE.
- Prescale=15, PAR_EN=1, par_err=0 → sequence START,DATA×8,PARITY,STOP; par_chk_en pulses once at edge_cnt==9; data_valid pulses once.
- Prescale=7, PAR_EN=1, par_err=1 at parity bit_end → return to IDLE with no data_valid; with UART_RX_FSM_ERR_FLAGS_EN, parity_error pulses once.
- RX_IN low for 2 clocks then high, strt_glitch=1 → enable=1 for exactly 8 cycles, then IDLE; no deser_en and no data_valid.
- Assert uart_rx_fsm_rst low during DATA bit 4 → outputs 0 immediately; a subsequent clean frame completes normally with one data_valid pulse.
- Two back-to-back frames with no idle bits, Prescale=31 → two data_valid pulses and both bytes deserialised correctly.
